// File: rtl/regfile_pkg.sv
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared defaults and port-slicing helpers for reg_file_mp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int c_def_dw    = 32;
    localparam int c_def_aw    = 5;
    localparam int c_def_nrd   = 2;
    localparam int c_def_nwr   = 1;
    localparam int c_zero_addr = 0;

    // LSB of port `port` inside a packed address bus.
    function automatic int addr_slice(input int port, input int aw);
        return port * aw;
    endfunction

    // LSB of port `port` inside a packed data bus.
    function automatic int data_slice(input int port, input int dw);
        return port * dw;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
// ============================================================================
// Module   : reg_file_scoreboard
// Brief    : One busy bit per register; issue sets, writeback clears, and
//            issue wins when both hit the same register in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_scoreboard
    import regfile_pkg::*;
#(
    parameter int AW  = c_def_aw,
    parameter int NWR = c_def_nwr
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_addr,
    output logic [(2**AW)-1:0]   busy,
    output logic                 any_busy
);

    localparam int c_depth = 2 ** AW;

    logic [c_depth-1:0] r_busy;
    logic [c_depth-1:0] w_set;
    logic [c_depth-1:0] w_clr;
    logic [c_depth-1:0] w_busy_nxt;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (iss_valid) begin
            w_set[iss_addr] = 1'b1;
        end
        for (int k = 0; k < NWR; k++) begin
            if (wen[k]) begin
                w_clr[waddr[addr_slice(k, AW) +: AW]] = 1'b1;
            end
        end
        // Register 0 can never have a pending producer.
        w_set[c_zero_addr] = 1'b0;
        w_clr[c_zero_addr] = 1'b0;
    end

    // A new producer supersedes a retiring one, so set dominates clear.
    always_comb begin
        w_busy_nxt = w_set | (r_busy & ~w_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy     = r_busy;
    assign any_busy = |r_busy;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module   : reg_file_mp
// Brief    : Multi-port register file (NRD comb reads, NWR sync writes) with
//            per-register scoreboard. Optional macro: REGFILE_BYPASS_EN
//            forwards same-cycle write data to matching read ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int DW  = c_def_dw,
    parameter int AW  = c_def_aw,
    parameter int NRD = c_def_nrd,
    parameter int NWR = c_def_nwr
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*AW-1:0]    waddr,
    input  logic [NWR*DW-1:0]    wdata,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*DW-1:0]    rdata,
    output logic [NRD-1:0]       rbusy,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_addr,
    output logic                 any_busy
);

    localparam int c_depth = 2 ** AW;

    logic [DW-1:0]      r_mem [c_depth];
    logic [c_depth-1:0] w_busy_vec;
    logic               w_any_busy;

    reg_file_scoreboard #(
        .AW  (AW),
        .NWR (NWR)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .waddr     (waddr),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy      (w_busy_vec),
        .any_busy  (w_any_busy)
    );

    // Ports are applied in index order so the highest-index port wins a clash.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wen[k] && (waddr[addr_slice(k, AW) +: AW] != AW'(c_zero_addr))) begin
                    r_mem[waddr[addr_slice(k, AW) +: AW]] <= wdata[data_slice(k, DW) +: DW];
                end
            end
        end
    end

    genvar j;
    generate
        for (j = 0; j < NRD; j++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic [DW-1:0] w_data;
            logic          w_busy;

            assign w_ra = raddr[addr_slice(j, AW) +: AW];

            always_comb begin
                w_data = r_mem[w_ra];
                w_busy = w_busy_vec[w_ra];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < NWR; k++) begin
                    if (wen[k] && (waddr[addr_slice(k, AW) +: AW] == w_ra)) begin
                        w_data = wdata[data_slice(k, DW) +: DW];
                        w_busy = 1'b0;
                    end
                end
`endif
                // Outputs are held at zero while reset is asserted.
                if (rst || (w_ra == AW'(c_zero_addr))) begin
                    w_data = '0;
                    w_busy = 1'b0;
                end
            end

            assign rdata[data_slice(j, DW) +: DW] = w_data;
            assign rbusy[j]                       = w_busy;
        end
    endgenerate

    assign any_busy = w_any_busy & ~rst;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// ============================================================================
// Module   : tb_reg_file_mp
// Brief    : Scoreboard bench for reg_file_mp (NRD=2, NWR=2) with an
//            array-based reference model; directed scenarios then random.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NWR-1:0]    wen = '0;
    logic [NWR*AW-1:0] waddr = '0;
    logic [NWR*DW-1:0] wdata = '0;
    logic [NRD*AW-1:0] raddr = '0;
    logic [NRD*DW-1:0] rdata;
    logic [NRD-1:0]    rbusy;
    logic              iss_valid = 1'b0;
    logic [AW-1:0]     iss_addr = '0;
    logic              any_busy;

    reg_file_mp #(.DW(DW), .AW(AW), .NRD(NRD), .NWR(NWR)) dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .any_busy  (any_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic        ab;
        logic [31:0] cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] m_mem [32];
    bit          m_busy [32];

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    end

    // Reference read: what decode must see for address a this cycle.
    function automatic void ref_read(input logic r, input logic [1:0] we,
                                     input logic [4:0] wa0, input logic [4:0] wa1,
                                     input logic [31:0] wd0, input logic [31:0] wd1,
                                     input logic [4:0] a,
                                     output logic [31:0] d, output logic b);
        d = m_mem[a];
        b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (we[1] && wa1 == a) begin
            d = wd1; b = 1'b0;
        end else if (we[0] && wa0 == a) begin
            d = wd0; b = 1'b0;
        end
`else
        if (we == 2'b11 && wa0 == wa1 && wd0 == 32'hFFFF_FFFF) d = m_mem[a];
`endif
        if (r || a == 5'd0) begin
            d = '0; b = 1'b0;
        end
    endfunction

    task automatic drive(input logic r, input logic [1:0] we,
                         input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1,
                         input logic iv, input logic [4:0] ia);
        exp_t e;
        bit   any;
        @(negedge clk);
        rst       = r;
        wen       = we;
        waddr     = {wa1, wa0};
        wdata     = {wd1, wd0};
        raddr     = {ra1, ra0};
        iss_valid = iv;
        iss_addr  = ia;
        ref_read(r, we, wa0, wa1, wd0, wd1, ra0, e.d0, e.b0);
        ref_read(r, we, wa0, wa1, wd0, wd1, ra1, e.d1, e.b1);
        any = 1'b0;
        for (int i = 1; i < 32; i++) any |= m_busy[i];
        e.ab  = r ? 1'b0 : any;
        e.cyc = cyc;
        q.push_back(e);
        cyc++;
        // Advance the model to the state after the coming posedge.
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i] = '0; m_busy[i] = 1'b0;
            end
        end else begin
            if (we[0] && wa0 != 0) m_mem[wa0] = wd0;
            if (we[1] && wa1 != 0) m_mem[wa1] = wd1;
            for (int a = 1; a < 32; a++) begin
                if (iv && ia == a)                                   m_busy[a] = 1'b1;
                else if ((we[0] && wa0 == a) || (we[1] && wa1 == a)) m_busy[a] = 1'b0;
            end
        end
    endtask

    task automatic cmp(input string nm, input logic [31:0] c, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, c, got, exp);
        end
    endtask

    // Monitor: the DUT presents its read outputs every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp("rdata0",   e.cyc, rdata[31:0],  e.d0);
                cmp("rdata1",   e.cyc, rdata[63:32], e.d1);
                cmp("rbusy0",   e.cyc, {31'd0, rbusy[0]}, {31'd0, e.b0});
                cmp("rbusy1",   e.cyc, {31'd0, rbusy[1]}, {31'd0, e.b1});
                cmp("any_busy", e.cyc, {31'd0, any_busy}, {31'd0, e.ab});
            end
        end
    end

    initial begin
        logic [4:0] a0, a1, r0, r1, ia;
        // Reset and read every register
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 2'b00, 0, 0, 0, 0, 0, 0, 1, 8);
        for (int i = 1; i < 32; i++) drive(0, 2'b00, 0, 0, 0, 0, 5'(i), 5'(32 - i), 0, 0);
        // Basic write / read, write to r0 dropped
        drive(0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 5, 0, 0, 0);
        drive(0, 2'b00, 0, 0, 0, 0, 5, 5, 0, 0);
        drive(0, 2'b01, 0, 0, 32'h1234, 0, 0, 5, 0, 0);
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        // Scoreboard: issue, writeback, simultaneous issue+writeback
        drive(0, 2'b00, 0, 0, 0, 0, 7, 7, 1, 7);
        drive(0, 2'b01, 7, 0, 32'h77, 0, 7, 7, 0, 0);
        drive(0, 2'b00, 0, 0, 0, 0, 7, 7, 0, 0);
        drive(0, 2'b10, 0, 7, 0, 32'h78, 7, 7, 1, 7);
        drive(0, 2'b00, 0, 0, 0, 0, 7, 7, 1, 0);
        drive(0, 2'b00, 0, 0, 0, 0, 7, 0, 0, 0);
        // Bypass scenario on r9
        drive(0, 2'b01, 9, 0, 32'h11, 0, 0, 9, 1, 9);
        drive(0, 2'b01, 9, 0, 32'hA5A5A5A5, 0, 9, 9, 0, 0);
        drive(0, 2'b00, 0, 0, 0, 0, 9, 9, 0, 0);
        // Dual-write conflict on busy r3
        drive(0, 2'b00, 0, 0, 0, 0, 3, 3, 1, 3);
        drive(0, 2'b11, 3, 3, 32'd1, 32'd2, 3, 3, 0, 0);
        drive(0, 2'b00, 0, 0, 0, 0, 3, 3, 0, 0);
        // Reset mid-operation
        drive(0, 2'b01, 4, 0, 32'h55, 0, 0, 0, 1, 4);
        drive(0, 2'b00, 0, 0, 0, 0, 4, 6, 1, 6);
        drive(1, 2'b00, 0, 0, 0, 0, 4, 8, 1, 8);
        drive(0, 2'b00, 0, 0, 0, 0, 4, 8, 0, 0);
        drive(0, 2'b00, 0, 0, 0, 0, 6, 8, 0, 0);
        // Random traffic on a narrow address window to force collisions
        for (int n = 0; n < 3000; n++) begin
            a0 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            r0 = 5'($urandom_range(0, 9));
            r1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 9));
            ia = 5'($urandom_range(0, 9));
            drive(($urandom_range(0, 99) == 0), 2'($urandom), a0, a1, $urandom, $urandom,
                  r0, r1, ($urandom_range(0, 2) == 0), ia);
        end
        drive(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #3;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case stimulus ever stalls.
    initial begin
        #500000;
        $display("FAIL timeout checks=%0d expected=finished", checks);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file with per-register scoreboard, for the pipelined CPU datapath.
- NRD combinational read ports and NWR synchronous write ports; register 0 is hardwired to zero.
- Scoreboard tracks one pending producer per register: set at issue, cleared at writeback.
- Each read port reports a busy flag so decode can stall on RAW hazards.

Parameters:
DW, 32, data width in bits
AW, 5, address width; depth = 2**AW registers
NRD, 2, number of read ports (1..4)
NWR, 1, number of write ports (1..2)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset rst, synchronous, active-high; clock clk
wen  input  NWR  per-port write enable
waddr  input  NWR*AW  write addresses; port k at bits [k*AW +: AW]
wdata  input  NWR*DW  write data; port k at bits [k*DW +: DW]
raddr  input  NRD*AW  read addresses, packed like waddr
rdata  output  NRD*DW  read data, combinational
rbusy  output  NRD  1 = addressed register has a pending write
iss_valid  input  1  mark iss_addr busy at next edge
iss_addr  input  AW  destination register of the issuing instruction
any_busy  output  1  OR of all scoreboard bits

Behaviour:
- Reset (rst=1 at posedge): all registers and all busy bits cleared. rst has priority over wen and iss_valid.
- Outputs during and after reset: rdata=0, rbusy=0, any_busy=0.
- Write: register[waddr_k] <= wdata_k at posedge when wen_k=1 and waddr_k!=0. Writes to address 0 are dropped.
- Same-cycle write conflict (two ports, same address): the higher-index port wins.
- Read: rdata_j = register[raddr_j], combinational, zero latency. Address 0 always reads 0 and is never busy.
- Scoreboard, per address a != 0:
  - set at posedge if iss_valid and iss_addr==a;
  - else cleared at posedge if any wen_k with waddr_k==a;
  - else held.
- Simultaneous issue and writeback to the same address: busy stays 1, because the new producer supersedes the old one.
- iss_valid with iss_addr=0 has no effect.
- Issue to an already-busy register: bit stays 1. Single-bit scoreboard, no counting.
- Write to a non-busy register: data is written, busy bit stays 0.
- any_busy is registered-state derived (OR of busy bits), combinational from state.
- No X propagation: all storage reset, all outputs driven.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - if raddr_j != 0 matches any waddr_k with wen_k=1 in the same cycle, rdata_j = wdata of the highest-index matching port;
  - rbusy_j = 0 for that read;
  - adds one write-to-read combinational path per read/write port pair.
- Undefined:
  - rdata_j returns the pre-write register value that cycle and the new value the next cycle;
  - rbusy_j = raw busy bit, still 1 during the writeback cycle;
  - decode stalls one extra cycle.

Decomposition:
- Package regfile_pkg: default DW/AW/NRD/NWR constants, the zero-register address constant, and the port slicing helper functions (addr_slice, data_slice).
- Sub-module reg_file_scoreboard: busy-bit array, set/clear priority logic, any_busy.
- The top level holds the storage array, read muxes and bypass logic.

Test Plan:
1. Reset and read: rst=1 for 2 cycles, then read r1..r31 -> all rdata=0, rbusy=0, any_busy=0.
2. Basic write/read: write r5=32'hDEADBEEF, next cycle raddr0=5 -> rdata0=32'hDEADBEEF. Write r0=32'h1234 -> raddr=0 reads 0.
3. Scoreboard sequence:
   - iss_valid, iss_addr=7 -> next cycle rbusy=1 for raddr=7, any_busy=1.
   - wen, waddr=7 -> next cycle rbusy=0, any_busy=0.
   - Issue and write r7 in the same cycle -> busy remains 1.
4. Bypass (REGFILE_BYPASS_EN defined vs undefined): r9 busy, writing 32'hA5A5A5A5 to r9 while raddr1=9.
   - Defined: rdata1=32'hA5A5A5A5, rbusy1=0 in the same cycle.
   - Undefined: old value and rbusy1=1, then the new value next cycle.
5. Dual-write conflict (NWR=2): port0 writes r3=1, port1 writes r3=2 in the same cycle -> r3 reads 2. Busy r3 is cleared.
6. Reset mid-operation: r4 and r6 busy, r4=32'h55; assert rst with iss_valid=1, iss_addr=8 -> all busy=0, r4 reads 0, r8 not busy.
